// File: rtl/upcounter_modulo_pkg.sv
// upcounter_modulo_pkg
//   Shared encodings for the modulo up/down counter and its next-value
//   calculator: counting mode (wrap or saturate) and counting direction.
package upcounter_modulo_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : upcounter_modulo_pkg

// File: rtl/upcounter_modulo_next.sv
// upcounter_modulo_next
//   Purely combinational next-value and event calculator for the counter.
//   Ports:
//     qe     in  SIZE    effective current value, already clamped to limit
//     step   in  STEP_W  step magnitude (zero-extended internally)
//     limit  in  SIZE    top of the count range [0, limit]
//     dir    in  dir_e   counting direction
//     mode   in  mode_e  wrap or saturate at the range boundary
//     next   out SIZE    value the counter takes on an enabled cycle
//     evt    out 1       boundary crossed (wrap) or hit (saturate)
module upcounter_modulo_next
    import upcounter_modulo_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int STEP_W = 4
) (
    input  logic [SIZE-1:0]   qe,
    input  logic [STEP_W-1:0] step,
    input  logic [SIZE-1:0]   limit,
    input  dir_e              dir,
    input  mode_e             mode,
    output logic [SIZE-1:0]   next,
    output logic              evt
);

    localparam logic [SIZE:0] ONE = {{SIZE{1'b0}}, 1'b1};

    // One extra bit so that qe+step and limit+1 never overflow.
    logic [SIZE:0] qe_x;
    logic [SIZE:0] step_x;
    logic [SIZE:0] limit_x;
    logic [SIZE:0] span;
    logic [SIZE:0] sum;

    assign qe_x    = {1'b0, qe};
    assign step_x  = (SIZE+1)'(step);
    assign limit_x = {1'b0, limit};
    assign span    = limit_x + ONE;
    assign sum     = qe_x + step_x;

    // NOTE: every output gets a default first so no path through the
    // branches leaves a value unassigned, which would infer a latch.
    always_comb begin
        next = qe;
        evt  = 1'b0;
        if (dir == DIR_UP) begin
            if (sum <= limit_x) begin
                next = SIZE'(sum);
            end else begin
                evt  = 1'b1;
                next = (mode == MODE_SAT) ? limit : SIZE'(sum - span);
            end
        end else begin
            if (qe_x >= step_x) begin
                next = SIZE'(qe_x - step_x);
            end else begin
                evt  = 1'b1;
                // With step <= limit+1 this stays non-negative and < span.
                next = (mode == MODE_SAT) ? '0 : SIZE'(qe_x + span - step_x);
            end
        end
    end

endmodule : upcounter_modulo_next

// File: rtl/upcounter_modulo.sv
// upcounter_modulo
//   Up/down counter over the runtime range [0, Limit] with programmable step,
//   wrap or saturate behaviour, parallel load, previous-value output and
//   terminal/overflow flags. All outputs are registered.
//   Ports:
//     Clock           in  1       rising-edge clock
//     Reset           in  1       synchronous, active-high reset
//     Initial         in  SIZE    value for Q and prev_Q on Reset
//     Enable          in  1       count when 1, hold when 0
//     Up              in  1       1 = count up, 0 = count down
//     Step            in  STEP_W  step magnitude (must not exceed Limit+1)
//     Limit           in  SIZE    top of count range
//     Mode_override   in  1       1 = use Mode, 0 = use SATURATE_DEFAULT
//     Mode            in  1       0 = wrap, 1 = saturate
//     Load            in  1       parallel load strobe
//     Load_value      in  SIZE    value to load (clamped to Limit)
//     Clear_flag      in  1       clears Overflow_sticky (a new event wins)
//     Q               out SIZE    current count
//     prev_Q          out SIZE    Q before its most recent load/count cycle
//     Terminal        out 1       one-cycle pulse after a boundary event
//     Overflow_sticky out 1       sticky boundary-event indicator
module upcounter_modulo
    import upcounter_modulo_pkg::*;
#(
    parameter int SIZE             = 8,
    parameter int STEP_W           = 4,
    parameter int SATURATE_DEFAULT = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [SIZE-1:0]   Initial,
    input  logic              Enable,
    input  logic              Up,
    input  logic [STEP_W-1:0] Step,
    input  logic [SIZE-1:0]   Limit,
    input  logic              Mode_override,
    input  logic              Mode,
    input  logic              Load,
    input  logic [SIZE-1:0]   Load_value,
    input  logic              Clear_flag,
    output logic [SIZE-1:0]   Q,
    output logic [SIZE-1:0]   prev_Q,
    output logic              Terminal,
    output logic              Overflow_sticky
);

    localparam logic [SIZE:0] ONE = {{SIZE{1'b0}}, 1'b1};

    logic [SIZE-1:0] count_q, count_d;
    logic [SIZE-1:0] prev_q, prev_d;
    logic            term_q, term_d;
    logic            sticky_q, sticky_d;

    logic [SIZE-1:0] qe;
    logic [SIZE-1:0] next;
    logic            evt;
    mode_e           mode_eff;
    logic            step_ok;

    // Clamping covers Limit being lowered below the current count.
    assign qe       = (count_q > Limit) ? Limit : count_q;
    assign mode_eff = mode_e'(Mode_override ? Mode : (SATURATE_DEFAULT != 0));
    assign step_ok  = ((SIZE+1)'(Step) <= ({1'b0, Limit} + ONE));

    upcounter_modulo_next #(
        .SIZE   (SIZE),
        .STEP_W (STEP_W)
    ) u_next (
        .qe    (qe),
        .step  (Step),
        .limit (Limit),
        .dir   (dir_e'(Up)),
        .mode  (mode_eff),
        .next  (next),
        .evt   (evt)
    );

    always_comb begin
        count_d  = count_q;
        prev_d   = prev_q;
        term_d   = 1'b0;
        sticky_d = Clear_flag ? 1'b0 : sticky_q;
        if (Load) begin
            count_d = (Load_value > Limit) ? Limit : Load_value;
            prev_d  = count_q;
        end else if (Enable) begin
            count_d = next;
            prev_d  = count_q;
            term_d  = evt;
            // A new event overrides a simultaneous clear.
            if (evt) begin
                sticky_d = 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q  <= Initial;
            prev_q   <= Initial;
            term_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            prev_q   <= prev_d;
            term_q   <= term_d;
            sticky_q <= sticky_d;
        end
    end

    // A step larger than Limit+1 has no defined result.
    always_ff @(posedge Clock) begin
        if (!Reset && !Load && Enable) begin
            a_step_legal: assert (step_ok);
        end
    end

    assign Q               = count_q;
    assign prev_Q          = prev_q;
    assign Terminal        = term_q;
    assign Overflow_sticky = sticky_q;

endmodule : upcounter_modulo
